// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, base opcodes
// and the build-time switch for immediate range checking.
// Build option: define IMM_RANGE_CHECK_EN to flag immediates that do not fit
// their instruction format.
package inst_encoder_pkg;

  // Instruction format selector carried on in_fmt; codes 6 and 7 are illegal
  typedef enum logic [2:0] {
    INST_FMT_R      = 3'd0,
    INST_FMT_I_ALU  = 3'd1,
    INST_FMT_I_LOAD = 3'd2,
    INST_FMT_S      = 3'd3,
    INST_FMT_B      = 3'd4,
    INST_FMT_J      = 3'd5
  } inst_fmt_e;

  // Base opcodes for each supported format
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  // Widths of the signed immediates each format can carry
  localparam int IMM_BITS_I = 12;
  localparam int IMM_BITS_B = 13;
  localparam int IMM_BITS_J = 21;

  // Range checking is compiled in or out as a constant gate so the checker
  // logic stays connected in both builds
`ifdef IMM_RANGE_CHECK_EN
  localparam logic IMM_RANGE_CHECK = 1'b1;
`else
  localparam logic IMM_RANGE_CHECK = 1'b0;
`endif

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field packer: builds the 32-bit instruction word from the
// decoded fields and flags illegal formats and out-of-range immediates.
// Build option: IMM_RANGE_CHECK_EN enables the immediate range flag.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_illegal,
  output logic        o_rangeErr
);

  logic w_fitsI;
  logic w_fitsB;
  logic w_fitsJ;
  logic w_rangeRaw;

  // An immediate fits N signed bits when every bit above N-2 matches the sign bit
  assign w_fitsI = (i_imm[31:IMM_BITS_I-1] == {(33-IMM_BITS_I){i_imm[IMM_BITS_I-1]}});
  assign w_fitsB = (i_imm[31:IMM_BITS_B-1] == {(33-IMM_BITS_B){i_imm[IMM_BITS_B-1]}});
  assign w_fitsJ = (i_imm[31:IMM_BITS_J-1] == {(33-IMM_BITS_J){i_imm[IMM_BITS_J-1]}});

  // Scatter the fields into their positions for the selected format; fields a format does not use stay zero
  always_comb begin
    o_inst     = '0;
    o_illegal  = 1'b0;
    w_rangeRaw = 1'b0;
    case (i_fmt)
      INST_FMT_R: begin
        o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPCODE_OP};
      end
      INST_FMT_I_ALU: begin
        o_inst     = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPCODE_OP_IMM};
        w_rangeRaw = !w_fitsI;
      end
      INST_FMT_I_LOAD: begin
        o_inst     = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPCODE_LOAD};
        w_rangeRaw = !w_fitsI;
      end
      INST_FMT_S: begin
        o_inst     = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPCODE_STORE};
        w_rangeRaw = !w_fitsI;
      end
      INST_FMT_B: begin
        o_inst     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], OPCODE_BRANCH};
        w_rangeRaw = !w_fitsB | i_imm[0];
      end
      INST_FMT_J: begin
        o_inst     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPCODE_JAL};
        w_rangeRaw = !w_fitsJ | i_imm[0];
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_rangeErr = IMM_RANGE_CHECK & w_rangeRaw;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder top: valid/ready input stream, one registered output
// stage carrying the packed word and its imem byte address, an
// auto-incrementing address counter and a sticky error flag.
// Build option: define IMM_RANGE_CHECK_EN to also raise err on immediates
// that do not fit their format.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ADDR_STEP  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  logic                  r_valid;
  logic [31:0]           r_inst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;

  logic [31:0] w_packed;
  logic        w_illegal;
  logic        w_rangeErr;
  logic        w_inBeat;
  logic        w_outBeat;
  logic        w_errEvent;

  inst_pack u_pack (
    .i_fmt      (in_fmt),
    .i_rd       (in_rd),
    .i_rs1      (in_rs1),
    .i_rs2      (in_rs2),
    .i_funct3   (in_funct3),
    .i_funct7   (in_funct7),
    .i_imm      (in_imm),
    .o_inst     (w_packed),
    .o_illegal  (w_illegal),
    .o_rangeErr (w_rangeErr)
  );

  // Handshakes are masked during reset so nothing is accepted or delivered in the reset cycle
  assign in_ready   = !rst & (!r_valid | out_ready);
  assign out_valid  = !rst & r_valid;
  assign out_inst   = r_inst;
  assign out_addr   = r_addr;
  assign err        = r_err;

  assign w_inBeat   = in_valid & in_ready;
  assign w_outBeat  = out_valid & out_ready;
  assign w_errEvent = w_illegal | w_rangeErr;

  // Output stage: a new beat overwrites the register, a drained beat with nothing behind it empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
    end else if (w_inBeat) begin
      r_valid <= 1'b1;
      r_inst  <= w_packed;
    end else if (w_outBeat) begin
      r_valid <= 1'b0;
    end
  end

  // Address counter: a load wins over the post-beat increment; wraparound is natural modulo arithmetic
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= RESET_ADDR;
    end else if (addr_load) begin
      r_addr <= addr_base;
    end else if (w_outBeat) begin
      r_addr <= r_addr + STEP;
    end
  end

  // Sticky error: a new error on an accepted beat beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_inBeat & w_errEvent) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed instructions with
// hand-encoded expected words and addresses feed a scoreboard queue that an
// independent monitor drains whenever the encoder delivers an output beat.
module tb_inst_encoder;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic        err_clr;

  exp_t sbQueue[$];
  int   testsRun  = 0;
  int   failCount = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err       (err),
    .err_clr   (err_clr)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // One comparison: bump the run count, and on a difference bump the failure count and report it
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, then queue its expected output
  task automatic applyStimulus(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input logic [31:0] expInst,
                               input logic [31:0] expAddr);
    int   waitCycles = 0;
    exp_t e;
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!in_ready) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL accept timeout: in_ready stayed 0, expected 1 within 50 cycles");
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      e.inst = expInst;
      e.addr = expAddr;
      sbQueue.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued word has been seen by the monitor
  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("scoreboard drain", 32'(sbQueue.size()), 32'd0);
  endtask

  // Hold err_clr for exactly one clock edge
  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Monitor: every delivered beat must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL unexpected output: inst 0x%08h addr 0x%08h with empty scoreboard",
                   out_inst, out_addr);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("out_inst", out_inst, e.inst);
          checkOutput("out_addr", out_addr, e.addr);
        end
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenario sequence
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; addr_load = 1'b0; addr_base = '0;
    out_ready = 1'b1; err_clr = 1'b0;

    // Reset: nothing accepted while asserted, reset values afterwards
    @(negedge clk);
    checkOutput("in_ready during reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_inst", out_inst, 32'd0);
    checkOutput("reset out_addr", out_addr, 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Each format; unused fields carry junk that must not leak into the word
    applyStimulus(3'd1, 5'd1, 5'd0, 5'd9, 3'd0, 7'h7F, 32'd5,        32'h00500093, 32'd0);
    applyStimulus(3'd2, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFC, 32'hFFC0A103, 32'd4);
    applyStimulus(3'd3, 5'd5, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8,        32'h0020A423, 32'd8);
    applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 32'd12);
    applyStimulus(3'd4, 5'd7, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFFFFF8, 32'hFE208CE3, 32'd16);
    applyStimulus(3'd5, 5'd1, 5'd3, 5'd4, 3'd5, 7'h7F, 32'd16,       32'h010000EF, 32'd20);
    applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h402081B3, 32'd24);
    waitDrain();
    checkOutput("err after legal stream", 32'(err), 32'd0);

    // Backpressure: first word held for 3 cycles while the next one waits
    out_ready = 1'b0;
    applyStimulus(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h00100213, 32'd28);
    in_valid = 1'b1; in_fmt = 3'd1; in_rd = 5'd5; in_imm = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall out_inst", out_inst, 32'h00100213);
      checkOutput("stall out_addr", out_addr, 32'd28);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h00200293, 32'd32);
    applyStimulus(3'd1, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h00300313, 32'd36);
    waitDrain();

    // Counter load in the same cycle as an output beat
    applyStimulus(3'd1, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, 32'h00700393, 32'd40);
    addr_load = 1'b1;
    addr_base = 32'h100;
    applyStimulus(3'd1, 5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8, 32'h00800413, 32'h100);
    addr_load = 1'b0;
    applyStimulus(3'd1, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9, 32'h00900493, 32'h104);
    waitDrain();

    // Wraparound at the top of the address space
    addr_load = 1'b1;
    addr_base = 32'hFFFFFFFC;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    applyStimulus(3'd1, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'd10, 32'h00A00513, 32'hFFFFFFFC);
    applyStimulus(3'd1, 5'd11, 5'd0, 5'd0, 3'd0, 7'h00, 32'd11, 32'h00B00593, 32'h0);
    waitDrain();

    // Illegal format: zero word, sticky err until cleared
    applyStimulus(3'd7, 5'd1, 5'd1, 5'd2, 3'd3, 7'h01, 32'd5, 32'h0, 32'd4);
    @(negedge clk);
    checkOutput("err after illegal fmt", 32'(err), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("err sticky", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    pulseErrClr();
    @(negedge clk);
    checkOutput("err after clear", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Clear and a new error in the same cycle: set wins
    err_clr = 1'b1;
    applyStimulus(3'd6, 5'd1, 5'd1, 5'd1, 3'd1, 7'h00, 32'd0, 32'h0, 32'd8);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err set beats clear", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    pulseErrClr();
    waitDrain();

    // Out-of-range I immediate: truncated word; err only with range checking built in
    applyStimulus(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h80000093, 32'd12);
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    checkOutput("err imm 2048", 32'(err), 32'd1);
`else
    checkOutput("err imm 2048", 32'(err), 32'd0);
`endif
    @(posedge clk);
    #1;
    pulseErrClr();
    waitDrain();

    // Reset with an output pending: it is dropped and the counter restarts
    out_ready = 1'b0;
    applyStimulus(3'd1, 5'd12, 5'd0, 5'd0, 3'd0, 7'h00, 32'd12, 32'h00C00613, 32'd16);
    rst = 1'b1;
    sbQueue.delete();
    @(negedge clk);
    checkOutput("out_valid in reset cycle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("out_valid after mid reset", 32'(out_valid), 32'd0);
    checkOutput("out_addr after mid reset", out_addr, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'd1, 5'd13, 5'd0, 5'd0, 3'd0, 7'h00, 32'd13, 32'h00D00693, 32'd0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
